// File: rtl/debounce_sync.sv
// -----------------------------------------------------------------------------
// debounce_sync
//   Conditions a raw asynchronous level (button, strap, external line) so it
//   can drive a d_ff D input directly.
//   1. D_in is synchronised into the CLK domain by a SYNC_STAGES-deep
//      flip-flop chain. The last stage is s.
//   2. s is debounced by a four-state FSM with a stability counter.
//      Q changes only after s has differed from Q on STABLE_CNT
//      consecutive rising edges.
//
// Optional feature (macro DEBOUNCE_EDGE_EN):
//   defined   : rise/fall are registered one-cycle pulses.
//               They are asserted on the same edge at which Q commits
//               0->1 or 1->0.
//   undefined : rise/fall are tied to 0 and no edge registers exist.
//
// Parameters:
//   SYNC_STAGES  synchroniser depth (>= 2)
//   STABLE_CNT   consecutive differing edges required before Q changes (>= 2)
//
// Ports:
//   CLK    in   rising-edge clock
//   n_res  in   synchronous active-low reset
//   D_in   in   raw asynchronous input level
//   Q      out  debounced, synchronised level (registered)
//   rise   out  one-cycle pulse on Q 0->1 (DEBOUNCE_EDGE_EN only, else 0)
//   fall   out  one-cycle pulse on Q 1->0 (DEBOUNCE_EDGE_EN only, else 0)
// -----------------------------------------------------------------------------
module debounce_sync #(
   parameter int SYNC_STAGES = 2,
   parameter int STABLE_CNT  = 16
) (
   input  logic CLK,
   input  logic n_res,
   input  logic D_in,
   output logic Q,
   output logic rise,
   output logic fall
);

   localparam int CNT_W = $clog2(STABLE_CNT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_LOW   = 2'd0,
      CHK_HIGH = 2'd1,
      ST_HIGH  = 2'd2,
      CHK_LOW  = 2'd3
   } state_t;

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   q_q, q_d;
   logic                   s;

   // Synchroniser: a plain shift chain. Bit 0 is the metastability-exposed
   // stage, so nothing may tap the chain before its last stage.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], D_in};
   end

   assign s = sync_q[SYNC_STAGES-1];

   // Debounce FSM.
   // The count enters a CHK state at 1 because the edge that causes the
   // entry is itself the first differing sample.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      q_d     = q_q;
      case (state_q)
         ST_LOW: begin
            if (s) begin
               state_d = CHK_HIGH;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d = '0;
            end
         end
         CHK_HIGH: begin
            if (!s) begin
               state_d = ST_LOW;   // glitch rejected, Q unchanged
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_HIGH;
               q_d     = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_HIGH: begin
            if (!s) begin
               state_d = CHK_LOW;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d = '0;
            end
         end
         CHK_LOW: begin
            if (s) begin
               state_d = ST_HIGH;  // glitch rejected, Q unchanged
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_LOW;
               q_d     = 1'b0;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = ST_LOW;
            cnt_d   = '0;
            q_d     = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!n_res) begin
         sync_q  <= '0;
         state_q <= ST_LOW;
         cnt_q   <= '0;
         q_q     <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         q_q     <= q_d;
      end
   end

   assign Q = q_q;

`ifdef DEBOUNCE_EDGE_EN
   logic rise_q, rise_d;
   logic fall_q, fall_d;

   // A commit is the only event that changes Q, so the difference between
   // the next and current Q marks the commit edge.
   always_comb begin
      rise_d = q_d & ~q_q;
      fall_d = ~q_d & q_q;
   end

   // Reset clears the pulses on the same edge that clears Q, so no pulse
   // is produced by reset.
   always_ff @(posedge CLK) begin
      if (!n_res) begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign rise = rise_q;
   assign fall = fall_q;
`else
   assign rise = 1'b0;
   assign fall = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// -----------------------------------------------------------------------------
// tb_debounce_sync
//   Directed and randomized stimulus for debounce_sync with SYNC_STAGES=2 and
//   STABLE_CNT=4. D_in and n_res are driven on the falling edge. Outputs are
//   checked 1ps after each rising edge.
//
//   The reference model describes the behaviour at a higher level:
//   - a queue that delays D_in by SYNC_STAGES edges;
//   - a run length counting consecutive edges at which the delayed level
//     differs from Q.
//   When the run reaches STABLE_CNT, Q takes the delayed level.
// -----------------------------------------------------------------------------
`timescale 1ps/1ps
module tb_debounce_sync;

   localparam int SYNC_STAGES = 2;
   localparam int STABLE_CNT  = 4;
   localparam int LATENCY     = SYNC_STAGES + STABLE_CNT;
`ifdef DEBOUNCE_EDGE_EN
   localparam bit EDGE_EN = 1'b1;
`else
   localparam bit EDGE_EN = 1'b0;
`endif

   logic CLK = 1'b0;
   logic n_res = 1'b0;
   logic D_in = 1'b0;
   logic Q, rise, fall;

   int n_vec = 0;
   int n_err = 0;

   debounce_sync #(
      .SYNC_STAGES(SYNC_STAGES),
      .STABLE_CNT (STABLE_CNT)
   ) dut (
      .CLK  (CLK),
      .n_res(n_res),
      .D_in (D_in),
      .Q    (Q),
      .rise (rise),
      .fall (fall)
   );

   // Clock: 100ps period.
   always #50 CLK = ~CLK;

   // Reference model state.
   bit m_pipe[$];
   bit m_q    = 1'b0;
   int m_run  = 0;
   bit m_rise = 1'b0;
   bit m_fall = 1'b0;

   // Advance the model by one rising edge, given the inputs seen at that edge.
   task automatic model_edge(input bit d, input bit nres);
      bit s;
      if (!nres) begin
         m_pipe.delete();
         for (int i = 0; i < SYNC_STAGES; i++) m_pipe.push_back(1'b0);
         m_q    = 1'b0;
         m_run  = 0;
         m_rise = 1'b0;
         m_fall = 1'b0;
      end else begin
         s      = m_pipe[SYNC_STAGES-1];
         m_rise = 1'b0;
         m_fall = 1'b0;
         if (s != m_q) begin
            m_run++;
            if (m_run == STABLE_CNT) begin
               m_q    = s;
               m_run  = 0;
               m_rise = EDGE_EN && s;
               m_fall = EDGE_EN && !s;
            end
         end else begin
            m_run = 0;
         end
         m_pipe.push_front(d);
         void'(m_pipe.pop_back());
      end
   endtask

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Driver: one clock edge with the given inputs, followed by the output checks.
   task automatic step(input bit d, input bit nres, input string tag);
      @(negedge CLK);
      D_in  = d;
      n_res = nres;
      @(posedge CLK);
      model_edge(d, nres);
      #1;
      check_bit({tag, "_q"}, Q, m_q);
      check_bit({tag, "_rise"}, rise, m_rise);
      check_bit({tag, "_fall"}, fall, m_fall);
   endtask

   // Hold D_in at d (reset released) until Q equals target.
   // lat is the edge number, starting at 1, at which Q reached target.
   // It is 0 if Q never reached target within the 20-edge bound.
   task automatic measure(input bit d, input bit target, input string tag,
                          output int lat);
      lat = 0;
      for (int e = 1; e <= 20; e++) begin
         step(d, 1'b1, tag);
         if (Q === target) begin
            lat = e;
            break;
         end
      end
   endtask

   int  lat;
   bit  q_hold;
   bit  saw_rise;
   int  hold_len;
   bit  lvl;
   bit  rst;

   initial begin
      // 1: reset with D_in=1, then release with D_in held high.
      step(1'b1, 1'b0, "rst0");
      step(1'b1, 1'b0, "rst1");
      check_bit("rst_q", Q, 1'b0);
      measure(1'b1, 1'b1, "rst_rel", lat);
      check_int("rst_rel_latency", lat, LATENCY);

      // 4: bounce from Q=1. The pattern is 0,1,0 and then D_in stays low.
      // The third step is the last 1->0 change and counts as edge 1.
      step(1'b0, 1'b1, "bnc");
      step(1'b1, 1'b1, "bnc");
      measure(1'b0, 1'b0, "bnc_fall", lat);
      check_int("bnc_latency", lat, LATENCY);
      check_bit("bnc_fall_pulse", fall, EDGE_EN);
      step(1'b0, 1'b1, "bnc_after");
      check_bit("bnc_fall_clear", fall, 1'b0);

      // 2: clean rise.
      measure(1'b1, 1'b1, "rise", lat);
      check_int("rise_latency", lat, LATENCY);
      check_bit("rise_pulse", rise, EDGE_EN);
      step(1'b1, 1'b1, "rise_after");
      check_bit("rise_pulse_clear", rise, 1'b0);

      // Return to Q=0 before the glitch test.
      measure(1'b0, 1'b0, "fall", lat);
      check_int("fall_latency", lat, LATENCY);

      // 3: a 3-cycle glitch must never reach Q.
      saw_rise = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b1, "glitch_hi");
         saw_rise |= Q | rise;
      end
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b1, "glitch_lo");
         saw_rise |= Q | rise;
      end
      check_bit("glitch_rejected", saw_rise, 1'b0);

      // 5: reset asserted at edge 4 of a pending rise.
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, "midrst_pre");
      step(1'b1, 1'b0, "midrst_edge");
      check_bit("midrst_q", Q, 1'b0);
      measure(1'b1, 1'b1, "midrst_rel", lat);
      check_int("midrst_latency", lat, LATENCY);

      // D_in toggling every cycle: Q must hold.
      q_hold = Q;
      for (int i = 0; i < 40; i++) begin
         step(i[0], 1'b1, "toggle");
      end
      check_bit("toggle_hold", Q, q_hold);

      // Randomized: random levels with random hold lengths, and occasional resets.
      for (int blk = 0; blk < 120; blk++) begin
         lvl      = 1'($urandom_range(0, 1));
         hold_len = $urandom_range(1, 7);
         for (int i = 0; i < hold_len; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            step(lvl, !rst, "rand");
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
